// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction / data) arbiter in front of a single
//               shared memory. Round-robin between the ports when both
//               request, one transaction at a time, with a wait-cycle
//               watchdog that aborts a grant the memory never answers.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   i_read, i_address         instruction port request (read only)
//   i_resp, i_rdata           instruction port completion pulse and data
//   d_read, d_write           data port requests (write wins if both high)
//   d_byte_enable             data port byte lanes ([1]=upper, [0]=lower)
//   d_address, d_wdata        data port address and write data
//   d_resp, d_rdata           data port completion pulse and data
//   err                       pulses with i_resp/d_resp on a timed-out access
//   mem_read, mem_write       shared memory strobes
//   mem_byte_enable           shared memory byte lanes
//   mem_address, mem_wdata    shared memory address and write data
//   mem_resp, mem_rdata       shared memory completion and read data
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic        i_resp,
  output logic [15:0] i_rdata,
  // data port
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_byte_enable,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic        d_resp,
  output logic [15:0] d_rdata,
  // status
  output logic        err,
  // shared memory
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  // Wait counter is at least 8 bits and wide enough to hold TIMEOUT.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  // The counter is compared one step early: the cycle in which it would
  // reach TIMEOUT is the last grant cycle, so a grant lasts at most
  // TIMEOUT cycles before the abort.
  localparam logic [CW-1:0] c_timeout_last = CW'(TIMEOUT - 1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_grant_i = 2'd1;
  localparam logic [1:0] c_grant_d = 2'd2;
  localparam logic [1:0] c_done    = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic          r_last_i;      // 1: the instruction port was granted last
  logic [CW-1:0] r_wait_cnt;
  logic          r_i_resp;
  logic          r_d_resp;
  logic          r_err;
  logic [15:0]   r_i_rdata;
  logic [15:0]   r_d_rdata;

  logic          w_i_req;
  logic          w_d_req;
  logic          w_timeout;
  logic          w_granted;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  assign w_granted = (r_state == c_grant_i) || (r_state == c_grant_d);
  assign w_timeout = w_granted && !mem_resp && (r_wait_cnt == c_timeout_last);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_i_req && w_d_req) begin
          // Contention: the port that did not win last time gets the bus.
          w_state_next = r_last_i ? c_grant_d : c_grant_i;
        end else if (w_i_req) begin
          w_state_next = c_grant_i;
        end else if (w_d_req) begin
          w_state_next = c_grant_d;
        end
      end
      c_grant_i, c_grant_d: begin
        if (mem_resp || w_timeout) begin
          w_state_next = c_done;
        end
      end
      // DONE is a single dead cycle: strobes low and requests ignored, so
      // the next access always starts with a fresh strobe edge.
      c_done:  w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, arbitration history, wait counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_idle;
      r_last_i   <= 1'b1;   // data port wins the first contention
      r_wait_cnt <= '0;
      r_i_resp   <= 1'b0;
      r_d_resp   <= 1'b0;
      r_err      <= 1'b0;
      r_i_rdata  <= 16'h0000;
      r_d_rdata  <= 16'h0000;
    end else begin
      r_state  <= w_state_next;
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      r_err    <= 1'b0;

      case (r_state)
        c_idle: begin
          if (w_state_next == c_grant_i) begin
            r_wait_cnt <= '0;
            r_last_i   <= 1'b1;
          end else if (w_state_next == c_grant_d) begin
            r_wait_cnt <= '0;
            r_last_i   <= 1'b0;
          end
        end
        c_grant_i: begin
          if (mem_resp) begin
            r_i_rdata <= mem_rdata;
            r_i_resp  <= 1'b1;
          end else if (w_timeout) begin
            // Aborted: report completion with err, keep the old data.
            r_i_resp <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        c_grant_d: begin
          if (mem_resp) begin
            r_d_rdata <= mem_rdata;
            r_d_resp  <= 1'b1;
          end else if (w_timeout) begin
            r_d_resp <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Shared memory request mux. Purely combinational from the state, so an
  // asynchronous reset drops the strobes at once, and the strobe falls on
  // the same clock edge that moves the FSM out of the grant state.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = d_address;
    mem_wdata       = d_wdata;
    case (r_state)
      c_grant_i: begin
        mem_read        = i_read;
        mem_byte_enable = 2'b11;
        mem_address     = i_address;
      end
      c_grant_d: begin
        // Simultaneous read and write is treated as a write.
        mem_write       = d_write;
        mem_read        = d_read & ~d_write;
        mem_byte_enable = d_byte_enable;
      end
      default: ;
    endcase
  end

  assign i_resp  = r_i_resp;
  assign d_resp  = r_d_resp;
  assign err     = r_err;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255; maximum cycles a granted transaction waits for mem_resp before aborting.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_read  input  1  instruction port read request; held until i_resp.
REQ-005 i_address  input  16  instruction port byte address.
REQ-006 i_resp  output  1  instruction port one-cycle completion pulse.
REQ-007 i_rdata  output  16  instruction port read data; valid while i_resp=1.
REQ-008 d_read, d_write  input  1 each  data port requests; held until d_resp.
REQ-009 d_byte_enable  input  2  data port byte lanes; [1] upper byte, [0] lower byte.
REQ-010 d_address, d_wdata  input  16 each  data port address and write data.
REQ-011 d_resp  output  1  data port one-cycle completion pulse.
REQ-012 d_rdata  output  16  data port read data; valid while d_resp=1.
REQ-013 err  output  1  one-cycle pulse with i_resp or d_resp when the transaction timed out.
REQ-014 mem_read, mem_write  output  1 each  shared memory strobes.
REQ-015 mem_byte_enable  output  2; mem_address, mem_wdata  output  16 each  shared memory request fields.
REQ-016 mem_resp  input  1; mem_rdata  input  16  shared memory completion and read data.

Function
REQ-017 FSM states: IDLE, GRANT_I, GRANT_D, DONE; the state SHALL be registered.
REQ-018 IDLE: if exactly one port requests, the next state SHALL be that port's GRANT state.
REQ-019 IDLE with both ports requesting: grant the port not granted last (round-robin); after reset the data port SHALL win first.
REQ-020 d_read and d_write both high SHALL be treated as a write; mem_read stays 0.
REQ-021 GRANT_x: mem_* outputs SHALL drive the granted port's fields combinationally; the other port's fields are ignored.
REQ-022 Outside GRANT states: mem_read=0, mem_write=0, mem_byte_enable=2'b00; mem_address and mem_wdata don't-care.
REQ-023 Instruction grant SHALL drive mem_write=0 and mem_byte_enable=2'b11.
REQ-024 GRANT_x with mem_resp=1: capture mem_rdata into the granted port's rdata register, pulse that port's resp the next cycle, and go to DONE.
REQ-025 Strobes SHALL fall at the end of the mem_resp cycle, so a zero-wait memory (resp in the first grant cycle) gives a one-cycle strobe.
REQ-026 DONE SHALL last exactly one cycle with strobes low, then go to IDLE, so every access produces a fresh strobe rising edge.
REQ-027 Requests sampled in DONE SHALL be ignored; the earliest new grant is the cycle after DONE.
REQ-028 Wait counter: 8+ bits, cleared on entering a GRANT state, incremented each GRANT cycle without mem_resp.
REQ-029 Counter reaching TIMEOUT SHALL abort to DONE, pulse the port's resp with err=1, and leave its rdata unchanged.
REQ-030 i_rdata and d_rdata SHALL hold their last captured value until the next capture for that port.
REQ-031 Latency from request to resp with a zero-wait memory: 2 cycles (grant cycle, then resp pulse in DONE).
REQ-032 A request dropped mid-grant is a protocol violation; the arbiter SHALL still complete the transaction.

Reset
REQ-033 rst=1 SHALL immediately force state to IDLE and the last-granted flag to "instruction", so data wins first.
REQ-034 rst=1 SHALL immediately clear i_resp, d_resp, err, the wait counter, i_rdata and d_rdata to 0, and mem strobes to 0.
REQ-035 Reset mid-grant SHALL abandon the transaction with no resp pulse after reset.

Verification
REQ-036 Zero-wait memory, d_write=1, d_address=16'h0010, d_wdata=16'hBEEF, d_byte_enable=2'b01 -> one-cycle mem_write, d_resp pulses at cycle 2, and memory byte 0x10=0xEF with byte 0x11 unchanged.
REQ-037 i_read and d_read asserted together after reset, each held until its resp -> data served first, instruction next, strictly alternating while both stay asserted.
REQ-038 Memory responding after 3 wait cycles to i_read at address 16'h0002 with rdata 16'h1234 -> mem_read high 4 cycles, i_rdata=16'h1234 with i_resp one cycle later.
REQ-039 Memory never responding, TIMEOUT=4 -> d_resp and err pulse together, strobe low in DONE, and d_rdata unchanged.
REQ-040 rst asserted during GRANT_D -> mem_write drops immediately, no d_resp is issued, and a following i_read is granted normally.
REQ-041 Back-to-back d_read requests -> mem_read shows a low cycle (DONE) between consecutive strobes.
